// File: rtl/button_pkg.sv
// Shared constants and types for the push-button reader.
// Cycle counts are derived from the 27 MHz board clock.
package button_pkg;

  localparam int CLK_HZ        = 27000000;
  localparam int CYCLES_PER_MS = CLK_HZ / 1000;
  localparam int DEBOUNCE_MS   = 10;
  localparam int HOLD_MS       = 500;
  localparam int REPEAT_MS     = 100;

  localparam int DEF_DEBOUNCE_CYCLES = CYCLES_PER_MS * DEBOUNCE_MS;
  localparam int DEF_HOLD_CYCLES     = CYCLES_PER_MS * HOLD_MS;
  localparam int DEF_REPEAT_CYCLES   = CYCLES_PER_MS * REPEAT_MS;

  localparam int NUM_BTN = 2;
  localparam int CNT_W   = 6;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    HELD      = 2'd1,
    REPEATING = 2'd2
  } rep_state_e;

  // Width of a counter that must reach cycles-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button channel: 2-FF synchroniser, debouncer and hold-to-repeat FSM.
// All outputs are registered; btn_n is active-low and asynchronous to clk.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic step_o
);

  localparam int DEB_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int REP_W  = cnt_width(REPEAT_CYCLES);
  localparam int TMR_W  = (HOLD_W > REP_W) ? HOLD_W : REP_W;

  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  rep_state_e       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             step_q, step_d;
  logic             pressed_s;
  logic             rise_s;
  logic             fall_s;

  // sync_q[1] is the synchronised pin; invert so 1 means pressed.
  assign sync_d    = {sync_q[0], btn_n};
  assign pressed_s = ~sync_q[1];

  // Debouncer: the level must differ for DEBOUNCE_CYCLES evaluations in a row.
  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = deb_cnt_q;
    rise_s    = 1'b0;
    fall_s    = 1'b0;
    if (pressed_s == stable_q) begin
      deb_cnt_d = {DEB_W{1'b0}};
    end else if (deb_cnt_q == DEB_LAST) begin
      stable_d  = ~stable_q;
      deb_cnt_d = {DEB_W{1'b0}};
      rise_s    = ~stable_q;
      fall_s    = stable_q;
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end
  end

  // Repeat FSM; an accepted release wins over any pending step.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    step_d    = 1'b0;
    press_d   = rise_s;
    release_d = fall_s;
    case (state_q)
      RELEASED: begin
        tmr_d = {TMR_W{1'b0}};
        if (rise_s) begin
          state_d = HELD;
          step_d  = 1'b1;
        end else begin
          state_d = RELEASED;
        end
      end
      HELD: begin
        if (fall_s) begin
          state_d = RELEASED;
          tmr_d   = {TMR_W{1'b0}};
        end else if (tmr_q == HOLD_LAST) begin
          state_d = REPEATING;
          tmr_d   = {TMR_W{1'b0}};
          step_d  = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      REPEATING: begin
        if (fall_s) begin
          state_d = RELEASED;
          tmr_d   = {TMR_W{1'b0}};
        end else if (tmr_q == REP_LAST) begin
          tmr_d  = {TMR_W{1'b0}};
          step_d = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        tmr_d   = {TMR_W{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      stable_q  <= 1'b0;
      deb_cnt_q <= {DEB_W{1'b0}};
      state_q   <= RELEASED;
      tmr_q     <= {TMR_W{1'b0}};
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      stable_q  <= stable_d;
      deb_cnt_q <= deb_cnt_d;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      press_q   <= press_d;
      release_q <= release_d;
      step_q    <= step_d;
    end
  end

  assign state_o   = stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign step_o    = step_q;

endmodule

// File: rtl/button_reader.sv
// Two debounced push-buttons stepping a 6-bit up/down counter shown on
// active-low LEDs. Button 0 counts up, button 1 counts down.
module button_reader
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_step,
  output logic [CNT_W-1:0]   led
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] led_q, led_d;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_n    (btn_n[i]),
      .state_o  (btn_state[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .step_o   (btn_step[i])
    );
  end

  // Simultaneous up and down steps cancel; wrap is natural modulo 64.
  always_comb begin
    count_d = count_q;
    case (btn_step)
      2'b01:   count_d = count_q + 6'd1;
      2'b10:   count_d = count_q - 6'd1;
      default: count_d = count_q;
    endcase
    led_d = ~count_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 6'd0;
      led_q   <= 6'h3F;
    end else begin
      count_q <= count_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_button_reader.sv
// Directed self-checking bench for button_reader with short debounce,
// hold and repeat periods so every timing boundary is reachable.
module tb_button_reader;
  import button_pkg::*;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_n;
  logic [1:0] btn_state;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_step;
  logic [5:0] led;

  int checks = 0;
  int errors = 0;

  button_reader #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_n      (btn_n),
    .btn_state  (btn_state),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_step   (btn_step),
    .led        (led)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press one button, hold it briefly (well under HOLD), release it.
  task automatic press_release(input int idx, input logic [5:0] exp_led);
    logic [1:0] mask;
    logic       seen;
    mask = 2'b01 << idx;
    seen = 1'b0;
    btn_n[idx] = 1'b0;
    repeat (5) begin
      tick();
      seen = seen | btn_press[idx];
    end
    check_eq("pr_no_early_press", 32'(seen), 32'd0);
    tick();
    check_eq("pr_press", 32'(btn_press), 32'(mask));
    check_eq("pr_step", 32'(btn_step), 32'(mask));
    btn_n[idx] = 1'b1;
    repeat (6) tick();
    check_eq("pr_release", 32'(btn_release), 32'(mask));
    check_eq("pr_led", 32'(led), 32'(exp_led));
  endtask

  initial begin
    logic seen;
    logic exp_step;

    rst_n = 1'b0;
    btn_n = 2'b11;
    repeat (3) tick();
    check_eq("rst_led", 32'(led), 32'h3F);
    check_eq("rst_state", 32'(btn_state), 32'd0);
    check_eq("rst_press", 32'(btn_press), 32'd0);
    check_eq("rst_release", 32'(btn_release), 32'd0);
    check_eq("rst_step", 32'(btn_step), 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_led", 32'(led), 32'h3F);

    // Bounce: 3 low / 1 high, five times, must never be accepted.
    seen = 1'b0;
    for (int b = 0; b < 5; b++) begin
      btn_n[0] = 1'b0;
      repeat (3) begin
        tick();
        seen = seen | btn_state[0] | btn_press[0];
      end
      btn_n[0] = 1'b1;
      tick();
      seen = seen | btn_state[0] | btn_press[0];
    end
    check_eq("bounce_no_press", 32'(seen), 32'd0);
    check_eq("bounce_led", 32'(led), 32'h3F);

    btn_n[0] = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      tick();
      seen = seen | btn_press[0];
    end
    check_eq("press_not_early", 32'(seen), 32'd0);
    tick();
    check_eq("press0", 32'(btn_press), 32'h1);
    check_eq("press0_state", 32'(btn_state), 32'h1);
    check_eq("press0_step", 32'(btn_step), 32'h1);

    // Auto-repeat: steps at +20, +28, ... ; released at +56.
    for (int off = 1; off <= 60; off++) begin
      tick();
      exp_step = (off < 56) && (off >= HOLD) && (((off - HOLD) % REP) == 0);
      check_eq("rpt_step", 32'(btn_step[0]), 32'(exp_step));
      check_eq("rpt_release", 32'(btn_release[0]), 32'(off == 56));
      if (off == 1) check_eq("press0_led", 32'(led), 32'h3E);
      if (off == 50) btn_n[0] = 1'b1;
    end
    check_eq("rpt_led", 32'(led), 32'h39);
    check_eq("rpt_state", 32'(btn_state), 32'd0);

    // Wrap both directions from zero.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_eq("wrap_start_led", 32'(led), 32'h3F);
    press_release(1, 6'h00);
    press_release(0, 6'h3F);

    // Simultaneous press and coinciding first repeat cancel out.
    btn_n = 2'b00;
    repeat (6) tick();
    check_eq("sim_press", 32'(btn_press), 32'h3);
    check_eq("sim_step", 32'(btn_step), 32'h3);
    tick();
    check_eq("sim_led", 32'(led), 32'h3F);
    repeat (18) tick();
    check_eq("sim_no_step19", 32'(btn_step), 32'd0);
    tick();
    check_eq("sim_rpt_step", 32'(btn_step), 32'h3);
    tick();
    check_eq("sim_rpt_led", 32'(led), 32'h3F);
    btn_n = 2'b11;
    repeat (6) tick();
    check_eq("sim_release", 32'(btn_release), 32'h3);
    check_eq("sim_rel_led", 32'(led), 32'h3F);

    // Reset while repeating, button held through reset.
    btn_n[0] = 1'b0;
    repeat (6) tick();
    check_eq("mh_press", 32'(btn_press), 32'h1);
    tick();
    check_eq("mh_led1", 32'(led), 32'h3E);
    repeat (19) tick();
    check_eq("mh_step20", 32'(btn_step), 32'h1);
    repeat (8) tick();
    check_eq("mh_step28", 32'(btn_step), 32'h1);
    tick();
    check_eq("mh_led3", 32'(led), 32'h3C);
    rst_n = 1'b0;
    tick();
    check_eq("mh_rst_led", 32'(led), 32'h3F);
    check_eq("mh_rst_state", 32'(btn_state), 32'd0);
    check_eq("mh_rst_step", 32'(btn_step), 32'd0);
    check_eq("mh_rst_fsm", 32'(dut.g_ch[0].u_ch.state_q), 32'(RELEASED));
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      tick();
      seen = seen | btn_press[0];
    end
    check_eq("mh_no_early_press", 32'(seen), 32'd0);
    tick();
    check_eq("mh_repress", 32'(btn_press), 32'h1);
    tick();
    check_eq("mh_repress_led", 32'(led), 32'h3E);
    btn_n[0] = 1'b1;
    repeat (6) tick();
    check_eq("mh_release", 32'(btn_release), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_reader.md
# button_reader

Input-side companion to the LED output path: samples the two on-board push-buttons (active-low, 27 MHz domain), synchronises and debounces them, and emits clean level, press and release indications with hold-to-auto-repeat. A 6-bit up/down counter stepped by button 0 (up) and button 1 (down) drives the six active-low LEDs. It sits directly between the board button pins and the LED pins, and other logic may consume its event pulses.

## Interface
- DEBOUNCE_CYCLES, 270000: consecutive stable cycles required to accept a level change (10 ms at 27 MHz); ≥2.
- HOLD_CYCLES, 13500000: cycles a button must stay pressed before auto-repeat starts (500 ms).
- REPEAT_CYCLES, 2700000: auto-repeat period once repeating (100 ms).
- clk  input  1  27 MHz board clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- btn_n  input  2  raw button pins, active-low, asynchronous to clk.
- btn_state  output  2  debounced level, 1 = pressed.
- btn_press  output  2  one-cycle pulse on accepted press.
- btn_release  output  2  one-cycle pulse on accepted release.
- btn_step  output  2  one-cycle pulse: press, or each auto-repeat tick.
- led  output  6  ~count (active-low LEDs).

## Operation
- Per button, independent channel:
  - 2-FF synchroniser. Both flops reset to 1 (released).
  - Debouncer: counter clears whenever synced level equals the stable level. Each cycle they differ, it increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, the stable level flips and the counter clears. A glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_state.
  - On a stable 0→1 (pressed) flip: btn_press=1 and btn_step=1 in the same cycle btn_state rises. On a 1→0 flip: btn_release=1 in the cycle btn_state falls.
  - Repeat FSM:
    - RELEASED → HELD on accepted press. Hold counter clears.
    - HELD → REPEATING when the hold counter reaches HOLD_CYCLES-1. Emit btn_step and clear the counter.
    - REPEATING: emit btn_step every REPEAT_CYCLES cycles.
    - Any state → RELEASED on accepted release. No step is emitted in the release cycle.
- Counter count[5:0]:
  - +1 on btn_step[0] alone; −1 on btn_step[1] alone.
  - No change when both step in the same cycle, or neither steps.
  - Wraps modulo 64 (63+1→0, 0−1→63).
- Reset, including mid-press or mid-debounce:
  - All counters and FSMs return to RELEASED.
  - count=0. btn_state, btn_press, btn_release and btn_step = 0. led = 6'b111111.
  - A button held through reset release is accepted as a new press after the normal debounce latency.

## Timing
- All outputs are registered. led is registered count, inverted.
- Press latency: if btn_n is first sampled low at edge N and stays low, btn_state/btn_press/btn_step assert after edge N+1+DEBOUNCE_CYCLES.
- Release latency is symmetric.
- count/led update on the edge after the btn_step pulse (1 cycle).
- First auto-repeat step: HOLD_CYCLES cycles after the press step. Subsequent steps: every REPEAT_CYCLES cycles.
- Counter widths derive from each parameter via $clog2. Do not hard-code them.

## Structure
- Shared package button_pkg:
  - default cycle constants (derived from CLK_HZ=27000000 and the ms values);
  - repeat FSM state enum {RELEASED, HELD, REPEATING}.
- One sub-module, button_channel: synchroniser + debouncer + repeat FSM for one button, instantiated twice.
- Top button_reader holds the up/down counter and LED inversion.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8.
- Reset: rst_n=0 for 3 cycles → led=6'h3F; btn_state, btn_press, btn_release, btn_step all 0.
- Bounce: btn_n[0] low 3 cycles, high 1 cycle, repeated 5 times → no press, led stays 6'h3F. Then hold low → btn_press[0] 5 cycles after the first low sample; led=6'h3E one cycle later.
- Auto-repeat: hold btn_n[0] low 60 cycles after the press → steps at press, +20, +28, +36, +44, +52 (6 total). led=~6 (6'h39); release → btn_release[0] pulse, no further steps.
- Wrap: count=0, press btn 1 once → led=~63=6'h00. Then press btn 0 once → led=6'h3F.
- Simultaneous: both buttons pressed on the same edge → btn_press=2'b11 in the same cycle, count unchanged. Their first repeats also coincide, so count stays unchanged.
- Reset mid-hold: assert rst_n while REPEATING → count=0 and the FSM returns to RELEASED. Button still held after reset release → btn_press after 5 cycles.
